// File: rtl/fifo_burst_reader.sv
// Read-side burst scheduler for the late-ready FIFO: drains it into a framed
// valid/ready stream, tracking occupancy locally from write accepts and pops.
module fifo_burst_reader #(
  parameter int DATAWIDTH = 18,
  parameter int ADDRWIDTH = 5,
  parameter int BURST     = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 wr_accept,
  input  logic                 fifo_ne,
  input  logic [DATAWIDTH-1:0] fifo_rd_data,
  output logic                 fifo_re,
  input  logic                 flush,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 burst_done,
  output logic                 err
);

  localparam int LW = ADDRWIDTH + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [LW-1:0] BURST_L  = LW'(BURST);
  localparam logic [LW-1:0] DEPTH_L  = LW'(1 << ADDRWIDTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_reg, state_next;
  logic [LW-1:0]   level_reg, level_next;
  logic [LW-1:0]   beat_reg, beat_next;
  logic [LW-1:0]   len_reg, len_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic            err_reg, err_next;
  logic            burst_done_reg, burst_done_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      level_reg      <= '0;
      beat_reg       <= '0;
      len_reg        <= '0;
      tmo_reg        <= '0;
      err_reg        <= 1'b0;
      burst_done_reg <= 1'b0;
    end else if (enable) begin
      state_reg      <= state_next;
      level_reg      <= level_next;
      beat_reg       <= beat_next;
      len_reg        <= len_next;
      tmo_reg        <= tmo_next;
      err_reg        <= err_next;
      burst_done_reg <= burst_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    level_next      = level_reg;
    beat_next       = beat_reg;
    len_next        = len_reg;
    tmo_next        = tmo_reg;
    burst_done_next = 1'b0;
    out_valid       = 1'b0;
    fifo_re         = 1'b0;
    out_data        = '0;
    out_first       = 1'b0;
    out_last        = 1'b0;

    // Stream outputs exist only while a burst is running; freeze blocks pops.
    if (state_reg == RUN) begin
      out_data  = fifo_rd_data;
      out_first = (beat_reg == '0);
      out_last  = (beat_reg == len_reg - LW'(1));
      if (enable) begin
        out_valid = fifo_ne;
        fifo_re   = fifo_ne && out_ready;
      end
    end

    // Occupancy saturates at both ends; a pop on empty is flagged, not wrapped.
    case ({wr_accept, fifo_re})
      2'b10:   if (level_reg != DEPTH_L) level_next = level_reg + LW'(1);
      2'b01:   if (level_reg != '0)      level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
    err_next = err_reg | (fifo_re && (level_reg == '0));

    case (state_reg)
      IDLE: begin
        if (level_reg == '0) begin
          tmo_next = '0;
        end else if (level_reg < BURST_L) begin
          tmo_next = tmo_reg + TW'(1);
        end
        if (level_reg >= BURST_L) begin
          state_next = RUN;
          len_next   = BURST_L;
          beat_next  = '0;
          tmo_next   = '0;
        end else if ((level_reg != '0) && (flush || (tmo_reg == TMO_LAST))) begin
          state_next = RUN;
          len_next   = level_reg;
          beat_next  = '0;
          tmo_next   = '0;
        end
      end
      RUN: begin
        tmo_next = '0;
        if (fifo_re) begin
          beat_next = beat_reg + LW'(1);
          if (out_last) begin
            state_next      = IDLE;
            burst_done_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign burst_done = burst_done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural late-ready FIFO, in-order word
// scoreboard, table-driven burst scenarios, hand-written corner cases, random run.
module tb_fifo_burst_reader;
  localparam int DW      = 18;
  localparam int AW      = 5;
  localparam int BURST   = 8;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          wr_accept = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          fifo_ne = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          fifo_re, out_valid, out_first, out_last, burst_done, err;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATAWIDTH(DW), .ADDRWIDTH(AW), .BURST(BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(rst), .enable(enable), .wr_accept(wr_accept),
    .fifo_ne(fifo_ne), .fifo_rd_data(fifo_rd_data), .fifo_re(fifo_re),
    .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
    .burst_done(burst_done), .err(err)
  );

  // FIFO model: a word accepted in cycle c becomes visible at the head in c+3.
  typedef struct {
    logic [DW-1:0] d;
    int            vis;
  } fent_t;
  fent_t         fq[$];
  int            cyc = 0;
  logic          re_s = 1'b0, acc_s = 1'b0, en_s = 1'b0, rst_s = 1'b1;
  logic [DW-1:0] d_s = '0;

  always @(negedge clk) begin
    re_s  = fifo_re;
    acc_s = wr_accept;
    en_s  = enable;
    rst_s = rst;
    d_s   = wr_data;
  end

  always @(posedge clk) begin
    fent_t e;
    cyc = cyc + 1;
    #1;
    if (rst_s) begin
      fq.delete();
    end else if (en_s) begin
      if (re_s && fq.size() > 0) void'(fq.pop_front());
      if (acc_s) begin
        e.d   = d_s;
        e.vis = cyc + 2;
        fq.push_back(e);
      end
    end
    fifo_ne      = (fq.size() > 0) && (fq[0].vis <= cyc);
    fifo_rd_data = fifo_ne ? fq[0].d : '0;
  end

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  int            beat_cnt = 0;
  int            last_len = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  bit            exp_bd = 0;
  bit            s_valid, s_re, s_first, s_last, s_bd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard at the negedge: in-order data, framing and stream-hold rules.
  task automatic monitor();
    logic [DW-1:0] e;
    s_valid = out_valid;
    s_re    = fifo_re;
    s_first = out_first;
    s_last  = out_last;
    s_bd    = burst_done;
    if (rst) begin
      exp_bd = 0; beat_cnt = 0; prev_stall = 0;
      exp_q.delete();
      return;
    end
    chk("burst_done", burst_done, exp_bd);
    chk("err", err, 0);
    if (prev_stall && enable) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
    end
    if (fifo_re) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("data", out_data, e);
      chk("first", out_first, beat_cnt == 0);
      beat_cnt++;
      if (out_last) begin
        chk("len_le_burst", beat_cnt <= BURST, 1);
        last_len = beat_cnt;
        beat_cnt = 0;
      end
    end
    if (enable) begin
      exp_bd     = fifo_re && out_last;
      prev_stall = out_valid && !fifo_re;
      prev_data  = out_data;
      if (wr_accept) exp_q.push_back(wr_data);
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr_accept = 0; flush = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    int nwords;
    bit use_flush;
    int exp_len;
    int exp_lat;
  } vec_t;

  // Writes nwords from k=0; flush pulses at k=8 and again at k=10 (in RUN).
  task automatic run_vec(input vec_t v, input int base);
    int first_k = -1;
    int beats = 0;
    bit done = 0;
    out_ready = 1;
    for (int k = 0; k < 200 && !done; k++) begin
      wr_accept = (k < v.nwords);
      wr_data   = DW'(base + k);
      flush     = v.use_flush && (k == 8 || k == 10);
      step();
      if (s_valid && first_k < 0) first_k = k;
      if (s_re) begin
        chk("vec_last", s_last, beats == v.exp_len - 1);
        chk("vec_first", s_first, beats == 0);
        beats++;
        if (s_last) done = 1;
      end
    end
    wr_accept = 0; flush = 0;
    chk("vec_latency", first_k, v.exp_lat);
    chk("vec_beats", beats, v.exp_len);
    step();
    chk("vec_done_pulse", s_bd, 1);
    chk("vec_drained", exp_q.size(), 0);
    idle(4);
  endtask

  initial begin
    vec_t vecs[5];
    int   pops, vcount, k;
    int   starts[$];

    vecs[0] = '{nwords: 8, use_flush: 0, exp_len: 8, exp_lat: 9};
    vecs[1] = '{nwords: 3, use_flush: 0, exp_len: 3, exp_lat: TIMEOUT + 1};
    vecs[2] = '{nwords: 5, use_flush: 1, exp_len: 5, exp_lat: 9};
    vecs[3] = '{nwords: 1, use_flush: 1, exp_len: 1, exp_lat: 9};
    vecs[4] = '{nwords: 7, use_flush: 0, exp_len: 7, exp_lat: TIMEOUT + 1};

    // Reset state
    rst = 1;
    idle(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_re", fifo_re, 0);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_err", err, 0);
    rst = 0;
    idle(3);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 16'h0001 + 16'h0100 * i);

    // Flush with nothing queued must not start a burst
    flush = 1; step(); flush = 0;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin step(); vcount += int'(s_valid); end
    chk("flush_empty", vcount, 0);

    // Backpressure: ready alternates every cycle
    pops = 0;
    for (k = 0; k < 100 && pops < 8; k++) begin
      wr_accept = (k < 8); wr_data = DW'(k + 16'h0A00);
      out_ready = (k % 2 == 0);
      step();
      pops += int'(s_re);
    end
    wr_accept = 0; out_ready = 1;
    chk("bp_pops", pops, 8);
    chk("bp_len", last_len, 8);
    idle(4);
    chk("bp_drained", exp_q.size(), 0);

    // Continuous writes: back-to-back full bursts, then a timed-out tail of 4
    starts.delete();
    out_ready = 1;
    for (k = 0; k < 300 && !(k > 20 && exp_q.size() == 0 && beat_cnt == 0); k++) begin
      wr_accept = (k < 20); wr_data = DW'(k + 16'h0B00);
      step();
      if (s_re && s_first) starts.push_back(k);
    end
    wr_accept = 0;
    chk("sim_nbursts", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("sim_start0", starts[0], 9);
      chk("sim_start1", starts[1], 18);
      chk("sim_start2", starts[2], 26 + TIMEOUT);
    end
    chk("sim_tail_len", last_len, 4);
    idle(4);

    // Asynchronous reset at beat 4
    pops = 0;
    for (k = 0; k < 100 && pops < 4; k++) begin
      wr_accept = (k < 8); wr_data = DW'(k + 16'h0C00);
      step();
      pops += int'(s_re);
    end
    wr_accept = 0;
    #1 rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_re", fifo_re, 0);
    chk("arst_first", out_first, 0);
    chk("arst_last", out_last, 0);
    chk("arst_data", out_data, 0);
    idle(2);
    rst = 0;
    vcount = 0;
    for (int i = 0; i < TIMEOUT + 10; i++) begin step(); vcount += int'(s_valid); end
    chk("arst_no_burst", vcount, 0);

    // Freeze mid-burst, then resume
    pops = 0;
    for (k = 0; k < 100 && pops < 3; k++) begin
      wr_accept = (k < 8); wr_data = DW'(k + 16'h0D00);
      step();
      pops += int'(s_re);
    end
    wr_accept = 0;
    enable = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_re", s_re, 0);
      chk("frz_valid", s_valid, 0);
    end
    enable = 1;
    for (k = 0; k < 50 && !(pops == 8 && s_last); k++) begin
      step();
      pops += int'(s_re);
    end
    chk("frz_pops", pops, 8);
    chk("frz_len", last_len, 8);
    idle(4);

    // Random traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 19) != 0);
      wr_accept = enable && (exp_q.size() < 28) && ($urandom_range(0, 2) == 0);
      wr_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    enable = 1; wr_accept = 0; flush = 0; out_ready = 1;
    for (k = 0; k < 400 && exp_q.size() != 0; k++) step();
    idle(4);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side scheduler for the late-ready synchronous FIFO. It drains the FIFO into a valid/ready stream in framed bursts of BURST words. A short partial burst is emitted when data has waited TIMEOUT cycles or when flush is requested. It keeps its own occupancy count, because the FIFO exposes only ne/af/cf.

Parameters:
DATAWIDTH, 18, FIFO word width
ADDRWIDTH, 5, FIFO depth is 2^ADDRWIDTH; level is ADDRWIDTH+1 bits
BURST, 8, full burst length in words (1..2^ADDRWIDTH)
TIMEOUT, 64, idle cycles with 0<level<BURST before a partial burst starts (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  global clock-enable; low freezes all state
wr_accept  in  1  FIFO write accepted this cycle (we && !cf at FIFO)
fifo_ne  in  1  FIFO not-empty; fifo_rd_data is the head word when high
fifo_rd_data  in  DATAWIDTH  FIFO head word
fifo_re  out  1  pop strobe to FIFO
flush  in  1  single-cycle pulse: start a partial burst now if level>0
out_data  out  DATAWIDTH  stream data (= fifo_rd_data)
out_valid  out  1  stream valid
out_ready  in  1  sink ready
out_first  out  1  first beat of a burst
out_last  out  1  last beat of a burst
burst_done  out  1  one-cycle pulse, registered, the cycle after the last beat transfers
err  out  1  sticky; set on pop with level==0; cleared only by reset

Behaviour:
- Reset (async, high): state=IDLE, level=0, beat=0, len=0, tmo=0, err=0, burst_done=0. All combinational outputs evaluate to 0.
- enable=0: no register changes, including level. fifo_re=0 and out_valid=0. This is a system-wide freeze; the FIFO freezes as well.
- level counter: next = level + wr_accept - pop, where pop = fifo_re. A simultaneous accept and pop leaves level unchanged. level never exceeds 2^ADDRWIDTH.
- level counts words up to 2 cycles before fifo_ne reflects them. fifo_ne always gates transfers, so a burst may stall mid-stream on an early level.
- States: IDLE, RUN.
- IDLE -> RUN, full burst: level>=BURST. Load len=BURST, beat=0, tmo=0.
- IDLE -> RUN, partial burst (len=level, level>0): flush=1, or tmo==TIMEOUT-1 with level>0. Load beat=0, tmo=0.
- Full-burst check has priority over flush and timeout.
- All start decisions use the registered level, so a write arriving in the same cycle is not counted in len.
- tmo: in IDLE, increments while 0<level<BURST; reset to 0 when level==0. Holds at 0 in RUN.
- Flush in RUN is ignored; it is not queued.
- RUN outputs, combinational:
  - out_valid = fifo_ne.
  - out_data = fifo_rd_data.
  - fifo_re = out_valid && out_ready.
  - out_first = (beat==0).
  - out_last = (beat==len-1).
- RUN transfer: on a transfer, beat increments.
- RUN exit: on a transfer with out_last, go to IDLE and pulse burst_done in the next cycle. A new burst can start the cycle after returning to IDLE, at the earliest.
- IDLE outputs: out_valid=0, fifo_re=0.
- A one-word burst asserts out_first and out_last together.
- Stream rule: once out_valid=1, it and out_data hold until a transfer. The FIFO ne cannot drop without a pop, so this holds by construction.
- err sets if fifo_re=1 while level==0; level then stays 0 (no wrap).
- Widths: level, len and beat are ADDRWIDTH+1 bits; tmo is clog2(TIMEOUT)+1 bits.

Test Plan:
1. Full burst: BURST=8, write 8 words (0x01..0x08) back-to-back, out_ready=1 -> 8 beats 0x01..0x08; out_first on 0x01, out_last on 0x08; burst_done one cycle later; level=0.
2. Backpressure: 8 words queued, out_ready toggled 1,0,1,0 -> data held stable while ready=0; exactly 8 fifo_re pulses; no duplicated or lost word.
3. Timeout: write 3 words then stop, TIMEOUT=64 -> no out_valid for 63 idle cycles; then a 3-beat burst with out_last on beat 3.
4. Flush: 5 words queued, pulse flush -> 5-beat partial burst starts the next cycle. A second flush in RUN is ignored. Flush with level=0 gives no burst.
5. Simultaneous events: continuous writes during a burst, with accept and pop in the same cycle -> level is consistent. A second full burst starts immediately after burst_done when level>=8.
6. Reset and freeze:
   - Assert reset mid-burst (beat=4) -> all outputs 0 asynchronously; state IDLE, level 0.
   - Drop enable mid-burst -> no fifo_re and beat holds; the burst resumes when enable returns.
